// File: rtl/serial_word_uart.sv
// serial_word_uart: full-duplex UART bridge packing received bytes into words and serialising words to bytes
module serial_word_uart #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int I_BYTES   = 1,
  parameter int O_BYTES   = 1,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 uart_txd_in,
  output logic                 uart_rxd_out,
  output logic [O_BYTES*8-1:0] o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  input  logic [I_BYTES*8-1:0] i_data,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic                 err_frame,
  output logic                 err_overrun
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam int OW = O_BYTES > 1 ? $clog2(O_BYTES) : 1;
  localparam int IW = I_BYTES > 1 ? $clog2(I_BYTES) : 1;
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t rx_state, rx_next, tx_state, tx_next;
  logic rx_meta, rx_line, rx_prev, rx_bad;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit, tx_bit;
  logic [7:0] rx_shift, tx_sh;
  logic [OW-1:0] rx_idx;
  logic [IW-1:0] tx_idx;
  logic [O_BYTES*8-1:0] rx_asm, rx_word;
  logic [I_BYTES*8-1:0] tx_word;
  logic tx_par;
  wire rx_tick = rx_state != IDLE && rx_cnt == '0;
  wire rx_end = rx_tick && rx_state == STOP;
  wire rx_ok = rx_end && rx_line && !rx_bad;
  wire rx_last = rx_idx == OW'(O_BYTES - 1);
  wire rx_load = rx_ok && rx_last && (!o_valid || o_ready);
  wire tx_tick = tx_state != IDLE && tx_cnt == '0;
  wire tx_next_byte = tx_tick && tx_state == STOP && tx_next == START;
  assign i_ready = tx_state == IDLE;
  // Completed word: the assembled lower lanes with the byte just received on top
  always_comb begin
    rx_word = rx_asm;
    rx_word[O_BYTES*8-1 -: 8] = rx_shift;
  end
  // Receive sequencing: advance one state per bit sample
  always_comb begin
    rx_next = rx_state;
    if (rx_state == IDLE) rx_next = rx_prev && !rx_line ? START : IDLE;
    else if (rx_tick)
      case (rx_state)
        START:   rx_next = rx_line ? IDLE : DATA;
        DATA:    rx_next = rx_bit != 3'd7 ? DATA : PARITY != 0 ? PAR : STOP;
        PAR:     rx_next = STOP;
        default: rx_next = IDLE;
      endcase
  end
  // Transmit sequencing: each bit lasts one full baud period, bytes chained back to back
  always_comb begin
    tx_next = tx_state;
    if (tx_state == IDLE) tx_next = i_valid ? START : IDLE;
    else if (tx_tick)
      case (tx_state)
        START:   tx_next = DATA;
        DATA:    tx_next = tx_bit != 3'd7 ? DATA : PARITY != 0 ? PAR : STOP;
        PAR:     tx_next = STOP;
        default: tx_next = tx_bit != 3'(STOP_BITS - 1) ? STOP : tx_idx == IW'(I_BYTES - 1) ? IDLE : START;
      endcase
  end
  // State registers for both directions
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_state <= IDLE;
      tx_state <= IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end
  // Receive datapath: synchroniser, bit timing, byte assembly and output holding register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rx_line <= 1'b1;
      rx_prev <= 1'b1;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_shift <= '0;
      rx_bad <= 1'b0;
      rx_idx <= '0;
      rx_asm <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      err_frame <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_meta <= uart_txd_in;
      rx_line <= rx_meta;
      rx_prev <= rx_line;
      rx_cnt <= rx_state == IDLE ? HALF : rx_tick ? FULL : rx_cnt - 1'b1;
      rx_bit <= rx_state == START ? 3'd0 : rx_tick && rx_state == DATA ? rx_bit + 1'b1 : rx_bit;
      if (rx_tick && rx_state == DATA) rx_shift <= {rx_line, rx_shift[7:1]};
      rx_bad <= rx_state == IDLE ? 1'b0 : rx_tick && rx_state == PAR ? (^rx_shift ^ rx_line) != (PARITY == 2) : rx_bad;
      if (rx_ok && !rx_last) rx_asm[rx_idx*8 +: 8] <= rx_shift;
      rx_idx <= (rx_end && !rx_ok) || (rx_ok && rx_last) ? '0 : rx_ok ? rx_idx + 1'b1 : rx_idx;
      if (rx_load) o_data <= rx_word;
      o_valid <= rx_load ? 1'b1 : o_valid && !o_ready;
      err_frame <= rx_end && !rx_ok;
      err_overrun <= rx_ok && rx_last && !rx_load;
    end
  end
  // Transmit datapath: the line is always a registered output
  always_ff @(posedge clk) begin
    if (!nrst) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_idx <= '0;
      tx_word <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      uart_rxd_out <= 1'b1;
    end else begin
      tx_cnt <= tx_state == IDLE || tx_tick ? FULL : tx_cnt - 1'b1;
      tx_bit <= tx_state == IDLE ? 3'd0 : tx_tick ? (tx_next != tx_state ? 3'd0 : tx_bit + 1'b1) : tx_bit;
      tx_idx <= tx_state == IDLE ? '0 : tx_next_byte ? tx_idx + 1'b1 : tx_idx;
      if (tx_state == IDLE && i_valid) tx_word <= i_data;
      else if (tx_next_byte) tx_word <= tx_word >> 8;
      if (tx_tick && tx_state == START) begin
        tx_sh <= {1'b0, tx_word[7:1]};
        tx_par <= ^tx_word[7:0] ^ (PARITY == 2);
      end else if (tx_tick && tx_state == DATA) tx_sh <= tx_sh >> 1;
      if (tx_state == IDLE && i_valid) uart_rxd_out <= 1'b0;
      else if (tx_tick)
        uart_rxd_out <= tx_next == START ? 1'b0 : tx_next == PAR ? tx_par : tx_next != DATA ? 1'b1 :
                        tx_state == START ? tx_word[0] : tx_sh[0];
    end
  end
endmodule

// File: tb/tb_serial_word_uart.sv
// tb_serial_word_uart: directed vectors for word reception, transmission, errors and reset
module tb_serial_word_uart;
  typedef struct {
    int          n;
    logic [23:0] bytes;
    logic [2:0]  stops;
    logic [15:0] word;
    int          ferr;
    int          rise;
  } rx_vec_t;
  logic clk = 1'b0;
  logic nrst, line, par_line, o_ready, i_valid;
  logic [15:0] i_data, o_data;
  logic uart_rxd_out, o_valid, i_ready, err_frame, err_overrun;
  logic p_txd, p_valid, p_iready, p_ef, p_eo;
  logic [7:0] p_data;
  logic p_ready = 1'b1;
  logic p_ivalid = 1'b0;
  logic [7:0] p_idata = 8'h00;
  int cyc = 0, vcyc = 0, xfer = 0, ef_cnt = 0, eo_cnt = 0, rise_cyc = 0;
  int pv = 0, pef = 0;
  logic [15:0] last_word = '0;
  logic [7:0] pword = '0;
  logic ov_prev = 1'b0;
  int errors = 0, checks = 0;
  rx_vec_t rxv [4];
  logic [15:0] txv [4];
  int v0, f0, x0, o0, st;
  always #5 clk = ~clk;
  serial_word_uart #(.CLK_HZ(100_000_000), .BAUD(1_000_000), .I_BYTES(2), .O_BYTES(2), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .nrst(nrst), .uart_txd_in(line), .uart_rxd_out(uart_rxd_out),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .err_frame(err_frame), .err_overrun(err_overrun));
  serial_word_uart #(.CLK_HZ(100_000_000), .BAUD(1_000_000), .I_BYTES(1), .O_BYTES(1), .PARITY(2), .STOP_BITS(1)) u_par (
    .clk(clk), .nrst(nrst), .uart_txd_in(par_line), .uart_rxd_out(p_txd),
    .o_data(p_data), .o_valid(p_valid), .o_ready(p_ready),
    .i_data(p_idata), .i_valid(p_ivalid), .i_ready(p_iready),
    .err_frame(p_ef), .err_overrun(p_eo));
  always @(posedge clk) cyc <= cyc + 1;
  // Output monitor: counts valid cycles, transfers, error pulses and notes when o_valid rises
  always @(negedge clk) begin
    if (o_valid) vcyc <= vcyc + 1;
    if (o_valid && o_ready) begin
      xfer <= xfer + 1;
      last_word <= o_data;
    end
    if (o_valid && !ov_prev) rise_cyc <= cyc;
    ov_prev <= o_valid;
    if (err_frame) ef_cnt <= ef_cnt + 1;
    if (err_overrun) eo_cnt <= eo_cnt + 1;
    if (p_valid) begin
      pv <= pv + 1;
      pword <= p_data;
    end
    if (p_ef) pef <= pef + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bits(input logic sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) par_line = bits[i];
      else line = bits[i];
      idle(100);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bits(1'b0, {2'b11, stop, b, 1'b0}, 10);
  endtask
  task automatic tx_check(input logic [15:0] w);
    logic [19:0] f;
    int bad, low;
    f = {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
    chk("tx_ready_idle", {31'd0, i_ready}, 1);
    i_data = w;
    i_valid = 1'b1;
    idle(1);
    i_valid = 1'b0;
    bad = 0;
    low = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (uart_rxd_out !== f[(k - 1) / 100]) bad++;
      if (!i_ready) low++;
      if (k % 100 == 0) begin
        chk($sformatf("tx_%h_bit%0d", w, (k - 1) / 100), bad, 0);
        bad = 0;
      end
    end
    chk("tx_ready_low_cycles", low, 2000);
    @(negedge clk);
    chk("tx_ready_rise", {31'd0, i_ready}, 1);
    idle(1);
  endtask
  initial begin
    nrst = 1'b0;
    line = 1'b1;
    par_line = 1'b1;
    o_ready = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    rxv[0] = '{2, 24'h001234, 3'b111, 16'h1234, 0, 1953};
    rxv[1] = '{3, 24'hABCD34, 3'b110, 16'hABCD, 1, 3053};
    rxv[2] = '{2, 24'h00FF00, 3'b111, 16'hFF00, 0, 1953};
    rxv[3] = '{2, 24'h008001, 3'b111, 16'h8001, 0, 1953};
    txv[0] = 16'hA55A;
    txv[1] = 16'h0001;
    txv[2] = 16'h8000;
    txv[3] = 16'h3C96;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      line = ~line;
      @(negedge clk);
      chk("reset_state", {uart_rxd_out, o_valid, o_data, i_ready, err_frame, err_overrun},
          {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0});
    end
    idle(1);
    nrst = 1'b1;
    line = 1'b1;
    idle(20);
    v0 = vcyc;
    send_byte(8'h77, 1'b1);
    line = 1'b0;
    idle(300);
    nrst = 1'b0;
    idle(3);
    line = 1'b1;
    idle(2);
    nrst = 1'b1;
    idle(1200);
    chk("reset_abort_no_valid", vcyc - v0, 0);
    for (int r = 0; r < 4; r++) begin
      v0 = vcyc;
      f0 = ef_cnt;
      st = cyc;
      for (int j = 0; j < rxv[r].n; j++) begin
        send_byte(rxv[r].bytes[8*j +: 8], rxv[r].stops[j]);
        if (!rxv[r].stops[j]) begin
          line = 1'b1;
          idle(100);
        end
      end
      idle(50);
      chk($sformatf("rx%0d_valid_cycles", r), vcyc - v0, 1);
      chk($sformatf("rx%0d_word", r), {16'd0, last_word}, {16'd0, rxv[r].word});
      chk($sformatf("rx%0d_frame_errs", r), ef_cnt - f0, rxv[r].ferr);
      chk($sformatf("rx%0d_valid_time", r), rise_cyc - st, rxv[r].rise);
    end
    o_ready = 1'b0;
    x0 = xfer;
    o0 = eo_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    idle(50);
    @(negedge clk);
    chk("ovr_valid_held", {31'd0, o_valid}, 1);
    chk("ovr_data_held", {16'd0, o_data}, 32'h0201);
    chk("ovr_pulses", eo_cnt - o0, 1);
    chk("ovr_no_xfer", xfer - x0, 0);
    idle(1);
    o_ready = 1'b1;
    idle(1);
    o_ready = 1'b0;
    @(negedge clk);
    chk("ovr_valid_fall", {31'd0, o_valid}, 0);
    chk("ovr_one_xfer", xfer - x0, 1);
    idle(1);
    o_ready = 1'b1;
    v0 = vcyc;
    f0 = ef_cnt;
    line = 1'b0;
    idle(30);
    line = 1'b1;
    idle(300);
    chk("glitch_no_valid", vcyc - v0, 0);
    chk("glitch_no_err", ef_cnt - f0, 0);
    v0 = vcyc;
    fork
      tx_check(16'hFFFF);
      begin
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
      end
    join
    idle(50);
    chk("duplex_rx_word", {16'd0, last_word}, 32'hA55A);
    chk("duplex_rx_valid", vcyc - v0, 1);
    for (int r = 0; r < 4; r++) tx_check(txv[r]);
    v0 = pv;
    f0 = pef;
    send_bits(1'b1, {1'b1, 1'b1, 1'b0, 8'h01, 1'b0}, 11);
    idle(50);
    chk("par_good_valid", pv - v0, 1);
    chk("par_good_data", {24'd0, pword}, 32'h01);
    chk("par_good_no_err", pef - f0, 0);
    v0 = pv;
    f0 = pef;
    send_bits(1'b1, {1'b1, 1'b1, 1'b1, 8'h01, 1'b0}, 11);
    idle(50);
    chk("par_bad_err", pef - f0, 1);
    chk("par_bad_no_valid", pv - v0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
